// File: rtl/mem_pkg.sv
// Shared definitions for the synchronous memory controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: init FSM state encoding, read-latency bounds, response control width.
package mem_pkg;

  // Init FSM: CLEAR walks the array writing zeros, IDLE serves requests.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Supported read latencies (accept edge to rsp_valid).
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Control bits carried alongside read data in the response pipe: {valid, err}.
  localparam int RSP_CTRL_W = 2;

  // Out-of-range latency parameters are pulled back into the supported range
  // so the pipe depth is always legal.
  function automatic int clamp_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-response delay line carrying {valid, err, data}.
// Latency: RD_LAT cycles from in_valid at an edge to out_valid.
// Backpressure: none; accepts one entry per cycle, flush empties every stage.
// Ports: clk; flush (sync clear); in_valid/in_err/in_data; out_valid/out_err/out_data.
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_err,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_err,
  output logic [WIDTH-1:0] out_data
);

  localparam int DEPTH = clamp_lat(RD_LAT);
  localparam int SW    = WIDTH + RSP_CTRL_W;

  logic [DEPTH-1:0][SW-1:0] stage;
  logic [SW-1:0]            stage_in;

  // Non-valid slots are forced to zero so data/err read as 0 between responses.
  assign stage_in = in_valid ? {1'b1, in_err, in_data} : '0;

  always_ff @(posedge clk) begin
    if (flush) begin
      stage <= '0;
    end else begin
      stage[0] <= stage_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign {out_valid, out_err, out_data} = stage[DEPTH-1];

endmodule

// File: rtl/sync_mem_ctrl.sv
// Single-port synchronous RAM with valid/ready requests and pipelined read responses.
// Latency: reads respond RD_LAT cycles after the accept edge; writes commit at the accept edge.
// Backpressure: req_ready low while the post-reset clear runs; responses cannot be stalled.
// Ports: clk, rst (sync, active high); req_valid/req_ready/req_write/req_addr/req_wdata;
//        rsp_valid/rsp_data/rsp_err; wr_err (dropped out-of-range write); busy (clearing).
module sync_mem_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIZE   = 100,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
  output logic              wr_err,
  output logic              busy
);

  localparam int                IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ADDR_W:0]   SIZE_X   = (ADDR_W + 1)'(SIZE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SIZE - 1);

  state_t           state;
  logic [IDX_W-1:0] clr_cnt;

  logic [WIDTH-1:0] mem [0:SIZE-1];

  logic             accept;
  logic             in_range;
  logic             wr_en;
  logic             rd_en;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] rd_word;

  // Reset overrides a handshake that happens to coincide with it.
  assign accept   = req_valid & req_ready & ~rst;
  // One extra bit so addresses at or above SIZE never alias into the array.
  assign in_range = ({1'b0, req_addr} < SIZE_X);
  assign idx      = req_addr[IDX_W-1:0];
  assign wr_en    = accept & req_write & in_range;
  assign rd_en    = accept & ~req_write;
  assign rd_word  = in_range ? mem[idx] : '0;

  // Init FSM with registered req_ready/busy; wr_err pulses the cycle after a dropped write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
      wr_err    <= 1'b0;
    end else begin
      wr_err <= accept & req_write & ~in_range;
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_IDX) begin
            state     <= ST_IDLE;
            clr_cnt   <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        ST_IDLE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= ST_CLEAR;
          clr_cnt   <= '0;
          req_ready <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

  // Array write port: the clear walk owns it during CLEAR, requests afterwards.
  // No reset here so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      mem[idx] <= req_wdata;
    end
  end

  // First pipe stage doubles as the RAM output register.
  mem_rd_pipe #(
    .WIDTH  (WIDTH),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (rst),
    .in_valid  (rd_en),
    .in_err    (~in_range),
    .in_data   (rd_word),
    .out_valid (rsp_valid),
    .out_err   (rsp_err),
    .out_data  (rsp_data)
  );

endmodule

// File: tb/tb_sync_mem_ctrl.sv
// Bench for sync_mem_ctrl: two instances (RD_LAT=1 and RD_LAT=2) share one request stream.
// Expected read responses are queued per instance with their due cycle and popped on rsp_valid.
module tb_sync_mem_ctrl;

  localparam int W  = 8;
  localparam int SZ = 100;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [W-1:0]  req_wdata = '0;

  logic          req_ready1, rsp_valid1, rsp_err1, wr_err1, busy1;
  logic [W-1:0]  rsp_data1;
  logic          req_ready2, rsp_valid2, rsp_err2, wr_err2, busy2;
  logic [W-1:0]  rsp_data2;

  always #5 clk = ~clk;

  sync_mem_ctrl #(.WIDTH(W), .SIZE(SZ), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
    .wr_err(wr_err1), .busy(busy1)
  );

  sync_mem_ctrl #(.WIDTH(W), .SIZE(SZ), .ADDR_W(AW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .rsp_err(rsp_err2),
    .wr_err(wr_err2), .busy(busy2)
  );

  typedef struct packed {
    logic          err;
    logic [W-1:0]  data;
    logic [31:0]   cyc;
  } exp_t;

  exp_t         q1[$];
  exp_t         q2[$];
  logic [W-1:0] model [0:255];
  logic [31:0]  cyc = '0;
  int           npass = 0;
  int           ntot  = 0;
  bit           mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Response monitors, sampled on the falling edge.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (mon_en) begin
      if (rsp_valid1 === 1'b1 && q1.size() != 0) begin
        e = q1.pop_front();
        check("rsp1_data", {24'd0, rsp_data1}, {24'd0, e.data});
        check("rsp1_err", {31'd0, rsp_err1}, {31'd0, e.err});
        check("rsp1_cycle", cyc, e.cyc);
      end else if (rsp_valid1 === 1'b1) begin
        check("rsp1_unexpected_valid", {31'd0, rsp_valid1}, 32'd0);
      end else begin
        check("rsp1_idle", {22'd0, rsp_valid1, rsp_err1, rsp_data1}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (mon_en) begin
      if (rsp_valid2 === 1'b1 && q2.size() != 0) begin
        e = q2.pop_front();
        check("rsp2_data", {24'd0, rsp_data2}, {24'd0, e.data});
        check("rsp2_err", {31'd0, rsp_err2}, {31'd0, e.err});
        check("rsp2_cycle", cyc, e.cyc);
      end else if (rsp_valid2 === 1'b1) begin
        check("rsp2_unexpected_valid", {31'd0, rsp_valid2}, 32'd0);
      end else begin
        check("rsp2_idle", {22'd0, rsp_valid2, rsp_err2, rsp_data2}, 32'd0);
      end
    end
  end

  // Drive one request for one cycle (caller is at a falling edge); reads queue their expectation.
  task automatic req(input bit w, input logic [AW-1:0] a, input logic [W-1:0] d);
    exp_t e;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    if (w) begin
      if (a < SZ) model[a] = d;
    end else begin
      e.err  = (a >= SZ);
      e.data = (a < SZ) ? model[a] : '0;
      e.cyc  = cyc + 1;
      q1.push_back(e);
      e.cyc  = cyc + 2;
      q2.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    req_write = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One-cycle reset, then measure the clear phase; optionally hold a write to addr 0 throughout.
  task automatic do_reset(input bit hold);
    int n1, n2, bad, guard;
    rst = 1'b1;
    @(posedge clk);
    #1;
    q1.delete();
    q2.delete();
    foreach (model[i]) model[i] = '0;
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (hold) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = '0;
      req_wdata = 8'hFF;
    end else begin
      req_valid = 1'b0;
    end
    check("rst_busy1", {31'd0, busy1}, 32'd1);
    check("rst_busy2", {31'd0, busy2}, 32'd1);
    check("rst_ready1", {31'd0, req_ready1}, 32'd0);
    check("rst_wr_err", {30'd0, wr_err1, wr_err2}, 32'd0);
    n1 = 0; n2 = 0; bad = 0; guard = 0;
    while ((busy1 !== 1'b0 || busy2 !== 1'b0) && guard < 300) begin
      if (busy1 === 1'b1) n1++;
      if (busy2 === 1'b1) n2++;
      if (req_ready1 !== 1'b0 || req_ready2 !== 1'b0) bad++;
      guard++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    req_write = 1'b0;
    check("busy1_cycles", n1, SZ);
    check("busy2_cycles", n2, SZ);
    check("ready_during_clear", bad, 32'd0);
    check("ready1_after_init", {31'd0, req_ready1}, 32'd1);
    check("ready2_after_init", {31'd0, req_ready2}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    do_reset(1'b0);

    // Every word reads back zero after init.
    for (int a = 0; a < SZ; a++) req(1'b0, AW'(a), '0);
    idle(3);

    // Write then read the same word on the very next cycle.
    req(1'b1, 8'd5, 8'hA5);
    check("wr_err_in_range", {30'd0, wr_err1, wr_err2}, 32'd0);
    req(1'b0, 8'd5, '0);
    idle(3);

    // Out-of-range write is dropped with a wr_err pulse; out-of-range read flags rsp_err.
    req(1'b1, 8'd100, 8'h3C);
    check("wr_err1_pulse", {31'd0, wr_err1}, 32'd1);
    check("wr_err2_pulse", {31'd0, wr_err2}, 32'd1);
    req(1'b0, 8'd100, '0);
    check("wr_err_cleared", {30'd0, wr_err1, wr_err2}, 32'd0);
    req(1'b0, 8'd99, '0);
    req(1'b0, 8'd255, '0);
    idle(3);

    // Streaming writes then back-to-back reads.
    for (int i = 0; i < 10; i++) req(1'b1, AW'(i), W'(10 + i));
    for (int i = 0; i < 10; i++) req(1'b0, AW'(i), '0);
    idle(4);

    // Reset while reads are in flight; a write held during the clear must be ignored.
    req(1'b0, 8'd5, '0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'd6;
    do_reset(1'b1);
    req(1'b0, 8'd0, '0);
    req(1'b0, 8'd5, '0);
    req(1'b0, 8'd6, '0);
    idle(5);

    check("q1_drained", q1.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
